dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Responder on the processor's data-memory bus (address_dmem / data / wren). It sits beside dmem and claims the top 256 words of the 12-bit word address space as memory-mapped I/O.
- It provides a TX FIFO that drains to an external valid/ready sink, a status register, and a free-running cycle counter.
- Read data returns with one-cycle latency, matching syncram timing, so the top level muxes q_mmio over q_dmem whenever mmio_hit is high.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, minimum 2.
- MMIO_BASE, 12'hF00, base of the claimed window; the window is MMIO_BASE..MMIO_BASE+255.

Ports:
- clock  in  1  single clock; runs on dmem_clock.
- reset  in  1  asynchronous, active-high.
- address_dmem  in  12  word address from processor.
- data  in  32  write data from processor.
- wren  in  1  write enable from processor.
- q_mmio  out  32  registered read data.
- mmio_hit  out  1  registered; high the cycle after an access that hit the window.
- tx_data  out  32  FIFO head word.
- tx_valid  out  1  high while FIFO non-empty.
- tx_ready  in  1  sink accepts when tx_valid && tx_ready.

Behaviour:
- Reset, asynchronous, all outputs:
  - FIFO empty; tx_valid=0, tx_data=0.
  - q_mmio=0, mmio_hit=0.
  - Cycle counter=0, overflow flag=0.
- Decode: hit = (address_dmem[11:8] == MMIO_BASE[11:8]); offset = address_dmem[7:0].
- Register map:
  - 0x00 TXDATA
    - Write pushes data[31:0] into the FIFO.
    - Read returns 0.
  - 0x01 STATUS, read:
    - bit0 empty, bit1 full.
    - bits[5:2] count (0..FIFO_DEPTH, saturates at 15).
    - bit6 overflow (sticky); other bits 0.
    - Write (any data) clears overflow.
  - 0x02 CYCLES
    - Read returns the 32-bit counter.
    - Write loads the counter with data.
  - All other offsets: reads return 0, writes are ignored.
- Read timing:
  - Every cycle, mmio_hit <= hit and q_mmio <= readmux(offset), or 0 when there is no hit.
  - wren does not suppress the read path.
- Cycle counter:
  - Increments by 1 every cycle and wraps 0xFFFFFFFF -> 0.
  - A write to CYCLES takes priority: the next value is data, not data+1.
  - A read in the same cycle as a write returns the pre-write value.
- Push/pop rules:
  - Push accepted when wren && hit && offset==0 && (!full || pop).
  - Push while full without a pop: word dropped, overflow <= 1, FIFO unchanged.
  - Pop when tx_valid && tx_ready; the head advances on the next edge.
  - Simultaneous push and pop:
    - Count unchanged.
    - Allowed when full; no overflow.
    - Allowed when count==1; the new word becomes head next cycle.
  - Push into an empty FIFO: no bypass. tx_valid rises the cycle after the write.
- Sink interface:
  - tx_data is stable while tx_valid && !tx_ready.
  - tx_valid never drops without a pop.
- Pointers wrap modulo FIFO_DEPTH. Count is tracked separately with width clog2(FIFO_DEPTH)+1.
- Overflow set and clear in the same cycle is impossible, because they target different offsets.
- Reset asserted mid-transfer discards FIFO contents; tx_valid drops asynchronously.

Decomposition:
- Shared header mmio_defs.vh holds the following localparams:
  - Offsets: MMIO_OFF_TXDATA=0, MMIO_OFF_STATUS=1, MMIO_OFF_CYCLES=2.
  - STATUS bit positions: ST_EMPTY=0, ST_FULL=1, ST_COUNT_LSB=2, ST_OVF=6.
- Sub-module sync_fifo (parameter DEPTH, WIDTH=32):
  - Inputs push, pop, wdata.
  - Outputs rdata(head), empty, full, count.
  - Same clock and asynchronous reset.
  - The top level holds decode, counter, status and read mux.

Test Plan:
1. Reset, then read STATUS (addr 0xF01) -> next cycle mmio_hit=1, q_mmio=0x00000001 (empty). Read 0x100 -> mmio_hit=0, q_mmio=0.
2. tx_ready=0; write 0xA5A50001..0xA5A50008 to 0xF00 -> STATUS=0x00000022 (full, count 8). Ninth write 0xDEADBEEF -> STATUS=0x62, FIFO unchanged. Write 0xF01 -> overflow bit cleared, STATUS=0x22.
3. Full FIFO, tx_ready=1 with a push of 0x12345678 in the same cycle -> count stays 8, no overflow. Drain order: 0xA5A50002 .. 0xA5A50008, then 0x12345678. tx_valid falls after the last pop.
4. tx_ready toggling 1,0,1,0 with 3 words queued -> tx_data held constant during ready=0 cycles. Exactly 3 transfers, in order.
5. Write 0xFFFFFFFE to 0xF02, then read on consecutive cycles -> read values 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap). A read in the write cycle returns the pre-write value.
6. Assert reset asynchronously mid-drain with 4 words queued -> tx_valid and mmio_hit go 0 immediately. After release STATUS=0x1 and CYCLES restarts from 0.

Source files
------------

// File: rtl/dmem_mmio_responder_pkg.sv
// Shared definitions for the data-memory MMIO responder: register offsets,
// STATUS bit positions and a small saturation helper for the count field.
package dmem_mmio_responder_pkg;

    // Word offsets inside the 256-word MMIO window
    localparam logic [7:0] MMIO_OFF_TXDATA = 8'h00;
    localparam logic [7:0] MMIO_OFF_STATUS = 8'h01;
    localparam logic [7:0] MMIO_OFF_CYCLES = 8'h02;

    // STATUS register bit positions
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_COUNT_LSB = 2;
    localparam int ST_OVF       = 6;

    // The count field is only 4 bits wide; deeper FIFOs report 15 when fuller
    function automatic logic [3:0] sat_count4(input logic [31:0] c);
        return (c > 32'd15) ? 4'd15 : c[3:0];
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_sync_fifo.sv
// Synchronous FIFO with a combinational head output. Pointers wrap modulo
// DEPTH (power of 2); occupancy is kept in a separate counter so full and
// empty are unambiguous.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_pop;
    logic w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == CW'(DEPTH));
    assign count  = r_count;
    // A pop on an empty FIFO is meaningless; a push when full only lands if a pop frees a slot
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);
    // Head is forced to zero when empty so stale storage never leaks out
    assign rdata  = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written only, never reset (contents are qualified by count)
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; reset discards all queued words
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// MMIO responder beside dmem: claims the top 256 words of the word address
// space, exposing a TX FIFO, a STATUS register and a free-running cycle
// counter. Read data is registered to match syncram one-cycle latency.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [11:0] MMIO_BASE  = 12'hF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_mmio,
    output logic        mmio_hit,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          w_hit;
    logic [7:0]    w_offset;
    logic          w_empty;
    logic          w_full;
    logic [CW-1:0] w_count;
    logic          w_pop;
    logic          w_push_req;
    logic          w_push;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_cyc_wr;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;

    logic [31:0]   r_cycles;
    logic          r_ovf;

    assign w_hit      = (address_dmem[11:8] == MMIO_BASE[11:8]);
    assign w_offset   = address_dmem[7:0];
    assign tx_valid   = !w_empty;
    assign w_pop      = tx_valid && tx_ready;
    assign w_push_req = wren && w_hit && (w_offset == MMIO_OFF_TXDATA);
    // A pop in the same cycle makes room, so a full FIFO can still accept
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = wren && w_hit && (w_offset == MMIO_OFF_STATUS);
    assign w_cyc_wr   = wren && w_hit && (w_offset == MMIO_OFF_CYCLES);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (data),
        .rdata (tx_data),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    // Assemble the STATUS word from FIFO flags and the sticky overflow bit
    always_comb begin
        w_status                      = '0;
        w_status[ST_EMPTY]            = w_empty;
        w_status[ST_FULL]             = w_full;
        w_status[ST_COUNT_LSB +: 4]   = sat_count4(32'(w_count));
        w_status[ST_OVF]              = r_ovf;
    end

    // Read mux; TXDATA and unmapped offsets read as zero, misses read as zero
    always_comb begin
        w_rdata = '0;
        if (w_hit) begin
            case (w_offset)
                MMIO_OFF_STATUS: w_rdata = w_status;
                MMIO_OFF_CYCLES: w_rdata = r_cycles;
                default:         w_rdata = '0;
            endcase
        end
    end

    // Registered read path; runs every cycle regardless of wren
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_mmio   <= '0;
            mmio_hit <= 1'b0;
        end else begin
            q_mmio   <= w_rdata;
            mmio_hit <= w_hit;
        end
    end

    // Free-running cycle counter; a CYCLES write loads data exactly (no +1)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycles <= '0;
        end else if (w_cyc_wr) begin
            r_cycles <= data;
        end else begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    // Sticky overflow: set on a dropped push, cleared by any STATUS write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for the MMIO responder: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_dmem_mmio_responder;

    localparam int DEPTH = 8;

    logic        clock;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_mmio;
    logic        mmio_hit;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int errors = 0;
    int checks = 0;

    dmem_mmio_responder #(
        .FIFO_DEPTH (DEPTH),
        .MMIO_BASE  (12'hF00)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_mmio       (q_mmio),
        .mmio_hit     (mmio_hit),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock edge and settle just after it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wren = 1'b0; address_dmem = 12'h000; data = '0; tx_ready = 1'b0;
        #12;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (tx_data !== 32'h0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
        checks++; if (mmio_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%0b exp=0", mmio_hit); end
        checks++; if (q_mmio !== 32'h0) begin errors++; $display("FAIL reset_q got=%h exp=0", q_mmio); end
        reset = 1'b0;
        address_dmem = 12'hF01;
        step();
        checks++; if (mmio_hit !== 1'b1) begin errors++; $display("FAIL status_hit got=%0b exp=1", mmio_hit); end
        checks++; if (q_mmio !== 32'h1) begin errors++; $display("FAIL status_empty got=%h exp=00000001", q_mmio); end
        address_dmem = 12'h100;
        step();
        checks++; if (mmio_hit !== 1'b0) begin errors++; $display("FAIL miss_hit got=%0b exp=0", mmio_hit); end
        checks++; if (q_mmio !== 32'h0) begin errors++; $display("FAIL miss_q got=%h exp=0", q_mmio); end
        $display("test_reset done");
    endtask

    task automatic test_overflow();
        tx_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            wren = 1'b1; address_dmem = 12'hF00; data = 32'hA5A50000 + 32'(i);
            step();
        end
        wren = 1'b0; address_dmem = 12'hF01;
        step();
        checks++; if (q_mmio !== 32'h22) begin errors++; $display("FAIL full_status got=%h exp=00000022", q_mmio); end
        wren = 1'b1; address_dmem = 12'hF00; data = 32'hDEADBEEF;
        step();
        wren = 1'b0; address_dmem = 12'hF01;
        step();
        checks++; if (q_mmio !== 32'h62) begin errors++; $display("FAIL ovf_status got=%h exp=00000062", q_mmio); end
        checks++; if (tx_data !== 32'hA5A50001) begin errors++; $display("FAIL ovf_head got=%h exp=a5a50001", tx_data); end
        wren = 1'b1; address_dmem = 12'hF01; data = $urandom;
        step();
        wren = 1'b0;
        step();
        checks++; if (q_mmio !== 32'h22) begin errors++; $display("FAIL ovf_clear got=%h exp=00000022", q_mmio); end
        $display("test_overflow done");
    endtask

    task automatic test_simul_push_pop();
        logic [31:0] exp_words [8];
        checks++; if (tx_data !== 32'hA5A50001) begin errors++; $display("FAIL simul_head got=%h exp=a5a50001", tx_data); end
        wren = 1'b1; address_dmem = 12'hF00; data = 32'h12345678; tx_ready = 1'b1;
        step();
        wren = 1'b0; address_dmem = 12'hF01; tx_ready = 1'b0;
        step();
        checks++; if (q_mmio !== 32'h22) begin errors++; $display("FAIL simul_status got=%h exp=00000022", q_mmio); end
        for (int i = 0; i < 7; i++) exp_words[i] = 32'hA5A50002 + 32'(i);
        exp_words[7] = 32'h12345678;
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_words[i]) begin
                errors++; $display("FAIL drain_%0d got=%h/%0b exp=%h/1", i, tx_data, tx_valid, exp_words[i]);
            end
            step();
        end
        tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%0b exp=0", tx_valid); end
        $display("test_simul_push_pop done");
    endtask

    task automatic test_ready_toggle();
        int n;
        tx_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            wren = 1'b1; address_dmem = 12'hF00; data = 32'hB0000000 + 32'(i);
            step();
        end
        wren = 1'b0; address_dmem = 12'h000;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tx_ready = (c % 2 == 0);
            if (tx_valid) begin
                checks++;
                if (n >= 3 || tx_data !== 32'hB0000001 + 32'(n)) begin
                    errors++; $display("FAIL toggle_c%0d got=%h exp=%h", c, tx_data, 32'hB0000001 + 32'(n));
                end
                if (tx_ready) n++;
            end
            step();
        end
        tx_ready = 1'b0;
        checks++; if (n !== 3) begin errors++; $display("FAIL toggle_count got=%0d exp=3", n); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL toggle_empty got=%0b exp=0", tx_valid); end
        $display("test_ready_toggle done transfers=%0d", n);
    endtask

    task automatic test_cycles();
        logic [31:0] exp_seq [4];
        exp_seq[0] = 32'hFFFFFFFE; exp_seq[1] = 32'hFFFFFFFF; exp_seq[2] = 32'h0; exp_seq[3] = 32'h1;
        wren = 1'b1; address_dmem = 12'hF02; data = 32'h100;
        step();
        wren = 1'b0;
        step();
        checks++; if (q_mmio !== 32'h100) begin errors++; $display("FAIL cyc_load got=%h exp=00000100", q_mmio); end
        wren = 1'b1; data = 32'hFFFFFFFE;
        step();
        checks++; if (q_mmio !== 32'h101) begin errors++; $display("FAIL cyc_prewrite got=%h exp=00000101", q_mmio); end
        wren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (q_mmio !== exp_seq[i]) begin errors++; $display("FAIL cyc_wrap_%0d got=%h exp=%h", i, q_mmio, exp_seq[i]); end
        end
        $display("test_cycles done");
    endtask

    task automatic test_async_reset();
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wren = 1'b1; address_dmem = 12'hF00; data = 32'hC0000000 + 32'(i);
            step();
        end
        wren = 1'b0; address_dmem = 12'hF01; tx_ready = 1'b1;
        step();
        checks++; if (mmio_hit !== 1'b1 || tx_valid !== 1'b1) begin errors++; $display("FAIL pre_areset hit=%0b valid=%0b exp=1/1", mmio_hit, tx_valid); end
        #2 reset = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%0b exp=0", tx_valid); end
        checks++; if (mmio_hit !== 1'b0) begin errors++; $display("FAIL areset_hit got=%0b exp=0", mmio_hit); end
        checks++; if (q_mmio !== 32'h0) begin errors++; $display("FAIL areset_q got=%h exp=0", q_mmio); end
        #2 reset = 1'b0;
        tx_ready = 1'b0; address_dmem = 12'hF02;
        step();
        checks++; if (q_mmio !== 32'h0) begin errors++; $display("FAIL areset_cycles got=%h exp=0", q_mmio); end
        address_dmem = 12'hF01;
        step();
        checks++; if (q_mmio !== 32'h1) begin errors++; $display("FAIL areset_status got=%h exp=00000001", q_mmio); end
        $display("test_async_reset done");
    endtask

    // Expected register value computed from the model state before an edge
    function automatic logic [31:0] model_read(input logic [11:0] a, input int unsigned qsize,
                                               input logic ovf, input logic [31:0] cyc);
        logic [31:0] v;
        int unsigned c;
        v = 32'h0;
        if (a[11:8] == 4'hF) begin
            if (a[7:0] == 8'h01) begin
                c = (qsize > 15) ? 15 : qsize;
                v = {25'h0, ovf, c[3:0], (qsize == DEPTH), (qsize == 0)};
            end else if (a[7:0] == 8'h02) begin
                v = cyc;
            end
        end
        return v;
    endfunction

    task automatic test_random();
        logic [31:0] m_q [$];
        logic [31:0] m_cyc;
        logic        m_ovf;
        logic [31:0] exp_q;
        logic        exp_hit;
        logic        pop;
        logic [11:0] addr_tab [6];
        addr_tab[0] = 12'hF00; addr_tab[1] = 12'hF01; addr_tab[2] = 12'hF02;
        addr_tab[3] = 12'hF07; addr_tab[4] = 12'h100; addr_tab[5] = 12'hF00;
        wren = 1'b0; tx_ready = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        m_q.delete(); m_cyc = 32'h0; m_ovf = 1'b0;
        for (int c = 0; c < 400; c++) begin
            wren = ($urandom_range(0, 2) != 0);
            address_dmem = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_tab[$urandom_range(0, 5)];
            data = $urandom;
            tx_ready = ($urandom_range(0, 2) == 0);
            // Sink-side outputs before the edge
            checks++;
            if (tx_valid !== (m_q.size() != 0)) begin
                errors++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, tx_valid, (m_q.size() != 0));
            end
            checks++;
            if (tx_data !== ((m_q.size() != 0) ? m_q[0] : 32'h0)) begin
                errors++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, tx_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
            end
            exp_hit = (address_dmem[11:8] == 4'hF);
            exp_q   = model_read(address_dmem, m_q.size(), m_ovf, m_cyc);
            // Model update for this edge
            pop = (m_q.size() != 0) && tx_ready;
            if (pop) void'(m_q.pop_front());
            if (wren && exp_hit && address_dmem[7:0] == 8'h00) begin
                if (m_q.size() < DEPTH) m_q.push_back(data);
                else m_ovf = 1'b1;
            end
            if (wren && exp_hit && address_dmem[7:0] == 8'h01) m_ovf = 1'b0;
            m_cyc = (wren && exp_hit && address_dmem[7:0] == 8'h02) ? data : m_cyc + 32'd1;
            step();
            checks++;
            if (mmio_hit !== exp_hit) begin errors++; $display("FAIL rnd_hit c=%0d got=%0b exp=%0b", c, mmio_hit, exp_hit); end
            checks++;
            if (q_mmio !== exp_q) begin errors++; $display("FAIL rnd_q c=%0d addr=%h got=%h exp=%h", c, address_dmem, q_mmio, exp_q); end
        end
        wren = 1'b0; tx_ready = 1'b0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_simul_push_pop();
        test_ready_toggle();
        test_cycles();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
